dcache_ctrl: RTL

- MEM-stage data-cache controller: direct-mapped, write-back, write-allocate L1 data cache between the EX/MEM pipeline register and off-chip data memory.
- Serves load/store hits with zero stall cycles.
- On a miss, asserts cpu_stall_o, which freezes every pipeline register including the downstream MEM/WB register, until the line is refilled.
- cpu_data_o is the MEM result captured by MEM/WB.

---
 rtl/cache_pkg.sv | 30 +++
 rtl/dcache_sram.sv | 62 ++++++
 rtl/dcache_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared sizing, FSM state type and address field helpers for the L1 data cache.
package cache_pkg;

    localparam int LINES    = 16;
    localparam int BLOCK_W  = 256;
    localparam int OFFSET_W = 5;
    localparam int IDX_W    = $clog2(LINES);
    localparam int TAG_W    = 32 - IDX_W - OFFSET_W;
    localparam int WORDS    = BLOCK_W / 32;
    localparam int WSEL_W   = $clog2(WORDS);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2
    } state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
        return a[31:IDX_W+OFFSET_W];
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
        return a[IDX_W+OFFSET_W-1:OFFSET_W];
    endfunction

    function automatic logic [WSEL_W-1:0] addr_word(input logic [31:0] a);
        return a[OFFSET_W-1:2];
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty and line storage: synchronous writes, asynchronous reads.
// Only valid and dirty bits are reset; tags and data keep whatever they held.
module dcache_sram
    import cache_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [IDX_W-1:0]   idx_i,
    input  logic               line_we_i,
    input  logic [BLOCK_W-1:0] line_i,
    input  logic               word_we_i,
    input  logic [WSEL_W-1:0]  word_sel_i,
    input  logic [31:0]        word_i,
    input  logic               set_dirty_i,
    input  logic               tag_we_i,
    input  logic [TAG_W-1:0]   tag_i,
    output logic               valid_o,
    output logic               dirty_o,
    output logic [TAG_W-1:0]   tag_o,
    output logic [BLOCK_W-1:0] line_o
);

    logic [BLOCK_W-1:0] data_q [LINES];
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [LINES-1:0]   valid_q;
    logic [LINES-1:0]   dirty_q;

    // Line storage: a refill replaces the whole line, a store hit merges one word.
    always_ff @(posedge clk_i) begin
        if (line_we_i) begin
            data_q[idx_i] <= line_i;
        end else if (word_we_i) begin
            data_q[idx_i][32*word_sel_i +: 32] <= word_i;
        end
    end

    // Tag storage, written together with the refilled line.
    always_ff @(posedge clk_i) begin
        if (tag_we_i) begin
            tag_q[idx_i] <= tag_i;
        end
    end

    // Valid/dirty: a tag write installs a clean valid line; a store marks it dirty.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (tag_we_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (set_dirty_i) begin
            dirty_q[idx_i] <= 1'b1;
        end
    end

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign line_o  = data_q[idx_i];

endmodule

// File: rtl/dcache_ctrl.sv
// MEM-stage direct-mapped write-back, write-allocate data cache controller.
// Memory handshake: mem_enable_o is a level request that stays high with
// mem_write_o/mem_addr_o/mem_data_o stable until memory returns a one-cycle
// mem_ack_i; mem_ack_i is only meaningful while a request is outstanding.
module dcache_ctrl
    import cache_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cpu_req_i,
    input  logic               cpu_write_i,
    input  logic [31:0]        cpu_addr_i,
    input  logic [31:0]        cpu_data_i,
    output logic [31:0]        cpu_data_o,
    output logic               cpu_stall_o,
    output logic               mem_enable_o,
    output logic               mem_write_o,
    output logic [31:0]        mem_addr_o,
    output logic [BLOCK_W-1:0] mem_data_o,
    input  logic [BLOCK_W-1:0] mem_data_i,
    input  logic               mem_ack_i,
    output state_t             dbg_state_o
);

    state_t             state_q, state_d;
    logic [TAG_W-1:0]   req_tag;
    logic [IDX_W-1:0]   req_idx;
    logic [WSEL_W-1:0]  req_word;
    logic               rd_valid, rd_dirty, hit;
    logic [TAG_W-1:0]   rd_tag;
    logic [BLOCK_W-1:0] rd_line;
    logic               line_we, tag_we, word_we;

    assign req_tag  = addr_tag(cpu_addr_i);
    assign req_idx  = addr_idx(cpu_addr_i);
    assign req_word = addr_word(cpu_addr_i);

    dcache_sram u_sram (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .idx_i       (req_idx),
        .line_we_i   (line_we),
        .line_i      (mem_data_i),
        .word_we_i   (word_we),
        .word_sel_i  (req_word),
        .word_i      (cpu_data_i),
        .set_dirty_i (word_we),
        .tag_we_i    (tag_we),
        .tag_i       (req_tag),
        .valid_o     (rd_valid),
        .dirty_o     (rd_dirty),
        .tag_o       (rd_tag),
        .line_o      (rd_line)
    );

    assign hit         = cpu_req_i & rd_valid & (rd_tag == req_tag);
    assign cpu_stall_o = (cpu_req_i & ~hit) | (state_q != IDLE);
    assign dbg_state_o = state_q;

    // Load result: selected word on a read hit, zero otherwise.
    always_comb begin
        cpu_data_o = '0;
        if (hit && !cpu_write_i) begin
            cpu_data_o = rd_line[32*req_word +: 32];
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and array write strobes; a reset cycle never updates a line.
    always_comb begin
        state_d = state_q;
        line_we = 1'b0;
        tag_we  = 1'b0;
        word_we = 1'b0;
        unique case (state_q)
            IDLE: begin
                word_we = hit & cpu_write_i & ~rst_i;
                if (cpu_req_i && !hit) begin
                    state_d = (rd_valid && rd_dirty) ? WRITEBACK : REFILL;
                end
            end
            WRITEBACK: begin
                if (mem_ack_i) state_d = REFILL;
            end
            REFILL: begin
                if (mem_ack_i) begin
                    state_d = IDLE;
                    line_we = ~rst_i;
                    tag_we  = ~rst_i;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory request registers, decoded from the state being entered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
        end else begin
            mem_enable_o <= (state_d != IDLE);
            mem_write_o  <= (state_d == WRITEBACK);
            unique case (state_d)
                WRITEBACK: begin
                    mem_addr_o <= {rd_tag, req_idx, {OFFSET_W{1'b0}}};
                    mem_data_o <= rd_line;
                end
                REFILL: begin
                    mem_addr_o <= {req_tag, req_idx, {OFFSET_W{1'b0}}};
                    mem_data_o <= '0;
                end
                default: begin
                    mem_addr_o <= '0;
                    mem_data_o <= '0;
                end
            endcase
        end
    end

endmodule
